// File: rtl/if_fetch_ctrl_pkg.sv
// ============================================================================
// Module      : if_fetch_ctrl_pkg
// Description : Shared constants and state encoding for the fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_ctrl_pkg;

   localparam int          INST_ADDR_WIDTH_DEF = 32;
   localparam int          IF_BATCH_SIZE_DEF   = 4;
   localparam logic [31:0] INST_INIT_DEF       = 32'h0000_1000;

   localparam int IF_FETCH_BYTES    = 16;
   localparam int IF_GROUP_OFF_BITS = 4;

   typedef enum logic [1:0] {
      IF_STATE_BOOT = 2'd0,
      IF_STATE_REQ  = 2'd1,
      IF_STATE_WAIT = 2'd2,
      IF_STATE_HOLD = 2'd3
   } if_state_e;

endpackage

`default_nettype wire

// File: rtl/if_fetch_ctrl_if.sv
// ============================================================================
// Module      : if_fetch_ctrl_if
// Description : I$ request/response and instruction-buffer delivery bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int BATCH  = 4
);
   logic                  ic_req_valid;
   logic                  ic_req_ready;
   logic [ADDR_W-1:0]     ic_req_addr;
   logic                  ic_resp_valid;
   logic [32*BATCH-1:0]   ic_resp_data;
   logic                  ib_valid;
   logic                  ib_ready;
   logic [ADDR_W-1:0]     ib_pc;
   logic [32*BATCH-1:0]   ib_insts;
   logic [BATCH-1:0]      ib_mask;

   // Fetch sequencer side
   modport master (
      output ic_req_valid, ic_req_addr, ib_valid, ib_pc, ib_insts, ib_mask,
      input  ic_req_ready, ic_resp_valid, ic_resp_data, ib_ready
   );

   // I$ / instruction-buffer side
   modport slave (
      input  ic_req_valid, ic_req_addr, ib_valid, ib_pc, ib_insts, ib_mask,
      output ic_req_ready, ic_resp_valid, ic_resp_data, ib_ready
   );
endinterface

`default_nettype wire

// File: rtl/if_fetch_ctrl_redir_arb.sv
// ============================================================================
// Module      : if_redir_arb
// Description : Priority select of next fetch PC: exception > branch > predictor
//               > sequential. Redirect targets have bits [1:0] forced to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_redir_arb #(
   parameter int ADDR_W = 32
) (
   input  wire logic              exc_valid,
   input  wire logic [ADDR_W-1:0] exc_pc,
   input  wire logic              br_valid,
   input  wire logic [ADDR_W-1:0] br_pc,
   input  wire logic              pred_valid,
   input  wire logic [ADDR_W-1:0] pred_pc,
   input  wire logic [ADDR_W-1:0] seq_pc,
   output logic      [ADDR_W-1:0] next_pc,
   output logic                   redirect_hit
);

   always_comb begin
      next_pc      = seq_pc;
      redirect_hit = 1'b0;
      if (exc_valid) begin
         next_pc      = exc_pc;
         redirect_hit = 1'b1;
      end else if (br_valid) begin
         next_pc      = br_pc;
         redirect_hit = 1'b1;
      end else if (pred_valid) begin
         next_pc = pred_pc;
      end
      next_pc[1:0] = 2'b00;
   end

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Fetch-stage sequencer: owns fetch PC, issues one group request
//               at a time, tags stale responses and delivers live groups.
//               Optional macro IF_PERF_CNT_EN adds performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W      = INST_ADDR_WIDTH_DEF,
   parameter int                BATCH       = IF_BATCH_SIZE_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(INST_INIT_DEF),
   parameter int                BOOT_CYCLES = 2
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              exc_redir_valid,
   input  wire logic [ADDR_W-1:0] exc_redir_pc,
   input  wire logic              br_redir_valid,
   input  wire logic [ADDR_W-1:0] br_redir_pc,
   input  wire logic              pred_taken,
   input  wire logic [1:0]        pred_lane,
   input  wire logic [ADDR_W-1:0] pred_target,
   if_fetch_ctrl_if.master        bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic      [31:0]       perf_groups,
   output logic      [31:0]       perf_killed,
   output logic      [31:0]       perf_ib_stall
`endif
);

   localparam int OFF_W  = $clog2(BATCH * 4);
   localparam int LANE_W = $clog2(BATCH);
   localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

   if_state_e             state_q, state_d;
   logic [ADDR_W-1:0]     fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]     req_pc_q, req_pc_d;
   logic                  kill_q, kill_d;
   logic [BOOT_W-1:0]     boot_cnt_q, boot_cnt_d;
   logic [32*BATCH-1:0]   insts_q, insts_d;
   logic [BATCH-1:0]      mask_q, mask_d;
   logic [ADDR_W-1:0]     ib_pc_q, ib_pc_d;

   logic [ADDR_W-1:0]     seq_pc;
   logic [ADDR_W-1:0]     arb_pc;
   logic                  redir_hit;
   logic [LANE_W-1:0]     first_lane;
   logic [BATCH-1:0]      live_mask;

   assign seq_pc     = {req_pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + ADDR_W'(BATCH * 4);
   assign first_lane = req_pc_q[OFF_W-1:2];

   if_redir_arb #(
      .ADDR_W (ADDR_W)
   ) u_redir_arb (
      .exc_valid    (exc_redir_valid),
      .exc_pc       (exc_redir_pc),
      .br_valid     (br_redir_valid),
      .br_pc        (br_redir_pc),
      .pred_valid   (pred_taken),
      .pred_pc      (pred_target),
      .seq_pc       (seq_pc),
      .next_pc      (arb_pc),
      .redirect_hit (redir_hit)
   );

   // Lanes before the entry offset and after a predicted-taken branch are dead
   always_comb begin
      live_mask = '0;
      for (int i = 0; i < BATCH; i++) begin
         live_mask[i] = (i >= int'(first_lane)) && (!pred_taken || (i <= int'(pred_lane)));
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      kill_d     = kill_q;
      boot_cnt_d = boot_cnt_q;
      insts_d    = insts_q;
      mask_d     = mask_q;
      ib_pc_d    = ib_pc_q;
      case (state_q)
         IF_STATE_BOOT: begin
            boot_cnt_d = boot_cnt_q + BOOT_W'(1);
            if (boot_cnt_q == BOOT_LAST) state_d = IF_STATE_REQ;
            if (redir_hit) fetch_pc_d = arb_pc;
         end
         IF_STATE_REQ: begin
            if (redir_hit) fetch_pc_d = arb_pc;
            if (bus.ic_req_ready) begin
               req_pc_d = fetch_pc_q;
               kill_d   = redir_hit;
               state_d  = IF_STATE_WAIT;
            end
         end
         IF_STATE_WAIT: begin
            if (bus.ic_resp_valid) begin
               kill_d = 1'b0;
               if (redir_hit || kill_q) begin
                  if (redir_hit) fetch_pc_d = arb_pc;
                  state_d = IF_STATE_REQ;
               end else begin
                  insts_d    = bus.ic_resp_data;
                  mask_d     = live_mask;
                  ib_pc_d    = req_pc_q;
                  fetch_pc_d = arb_pc;
                  state_d    = IF_STATE_HOLD;
               end
            end else if (redir_hit) begin
               kill_d     = 1'b1;
               fetch_pc_d = arb_pc;
            end
         end
         IF_STATE_HOLD: begin
            // A flush also clears the buffer, so a coincident ib_ready still counts
            if (redir_hit) begin
               fetch_pc_d = arb_pc;
               state_d    = IF_STATE_REQ;
            end else if (bus.ib_ready) begin
               state_d = IF_STATE_REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IF_STATE_BOOT;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         kill_q     <= 1'b0;
         boot_cnt_q <= '0;
         insts_q    <= '0;
         mask_q     <= '0;
         ib_pc_q    <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         kill_q     <= kill_d;
         boot_cnt_q <= boot_cnt_d;
         insts_q    <= insts_d;
         mask_q     <= mask_d;
         ib_pc_q    <= ib_pc_d;
      end
   end

   assign bus.ic_req_valid = (state_q == IF_STATE_REQ);
   assign bus.ic_req_addr  = {fetch_pc_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign bus.ib_valid     = (state_q == IF_STATE_HOLD);
   assign bus.ib_pc        = ib_pc_q;
   assign bus.ib_insts     = insts_q;
   assign bus.ib_mask      = mask_q;

   resp_only_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
      bus.ic_resp_valid |-> (state_q == IF_STATE_WAIT));

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_groups_q, perf_groups_d;
   logic [31:0] perf_killed_q, perf_killed_d;
   logic [31:0] perf_ib_stall_q, perf_ib_stall_d;

   always_comb begin
      perf_groups_d   = perf_groups_q;
      perf_killed_d   = perf_killed_q;
      perf_ib_stall_d = perf_ib_stall_q;
      if ((state_q == IF_STATE_HOLD) && bus.ib_ready)  perf_groups_d   = perf_groups_q + 32'd1;
      if ((state_q == IF_STATE_HOLD) && !bus.ib_ready) perf_ib_stall_d = perf_ib_stall_q + 32'd1;
      if ((state_q == IF_STATE_WAIT) && bus.ic_resp_valid && (kill_q || redir_hit))
         perf_killed_d = perf_killed_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_groups_q   <= '0;
         perf_killed_q   <= '0;
         perf_ib_stall_q <= '0;
      end else begin
         perf_groups_q   <= perf_groups_d;
         perf_killed_q   <= perf_killed_d;
         perf_ib_stall_q <= perf_ib_stall_d;
      end
   end

   assign perf_groups   = perf_groups_q;
   assign perf_killed   = perf_killed_q;
   assign perf_ib_stall = perf_ib_stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch-stage sequencer. It owns the fetch PC, issues one aligned 4-instruction group request at a time to the I$, and arbitrates PC redirect sources (exception > branch mispredict > predictor). Responses are tagged stale or live, and live groups are delivered to the instruction buffer with a lane-valid mask. It sits between the backend flush logic, the branch predictor, the I$ port and the instruction buffer.

Parameters:
ADDR_W, `INST_ADDR_WIDTH (32), PC width
BATCH, `IF_BATCH_SIZE (4), instructions per fetch group
RESET_PC, `INST_INIT, PC after reset
BOOT_CYCLES, 2, idle cycles after reset release before the first request

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exc_redir_valid  in  1  exception/trap redirect
exc_redir_pc  in  ADDR_W  exception target
br_redir_valid  in  1  branch mispredict redirect
br_redir_pc  in  ADDR_W  corrected target
pred_taken  in  1  predictor: current response group contains a taken branch
pred_lane  in  2  lane index of the predicted-taken branch
pred_target  in  ADDR_W  predicted target
ic_req_valid  out  1  I$ request valid
ic_req_ready  in  1  I$ accepts request
ic_req_addr  out  ADDR_W  16-byte-aligned group address
ic_resp_valid  in  1  I$ response (one cycle, no backpressure)
ic_resp_data  in  32*BATCH  lane i = bits [32i+31:32i]
ib_valid  out  1  group valid to instruction buffer
ib_ready  in  1  instruction buffer accepts
ib_pc  out  ADDR_W  PC of first valid lane
ib_insts  out  32*BATCH  instruction lanes
ib_mask  out  BATCH  lane-valid mask

Behaviour:
- Reset (async): state=BOOT, fetch_pc=RESET_PC, kill=0, boot counter=0. Outputs ic_req_valid=0, ic_req_addr=RESET_PC aligned, ib_valid=0, ib_mask=0, ib_insts=0, ib_pc=RESET_PC.
- States: BOOT, REQ, WAIT, HOLD.
- BOOT: count BOOT_CYCLES, then go to REQ.
- REQ: ic_req_valid=1, ic_req_addr={fetch_pc[ADDR_W-1:4],4'b0}. Address is stable while valid && !ready. Handshake (valid&&ready) latches req_pc=fetch_pc and goes to WAIT.
- WAIT: wait for ic_resp_valid.
  - Stale (kill=1): discard the response, clear kill, go to REQ.
  - Live: latch data; mask lanes from fetch_pc[3:2] upward. If pred_taken, clear lanes > pred_lane and set next fetch_pc=pred_target; otherwise fetch_pc=aligned+16. Go to HOLD.
- HOLD: ib_valid=1. On ib_ready, go to REQ next cycle. Minimum turnaround is therefore 3 cycles per group.
- One outstanding request maximum. A response arriving outside WAIT is an error; it is ignored and flagged in the assertion.
- Redirect, same cycle: exc wins over br. The target is written to fetch_pc and overrides any predictor update that cycle. Effect by state:
  - BOOT: fetch_pc replaced, boot continues.
  - REQ, not yet accepted: fetch_pc updated. Address change is permitted only here, because a redirect is a flush. Stay in REQ.
  - REQ, accepted in the redirect cycle: go to WAIT with kill=1.
  - WAIT: kill=1, unless ic_resp_valid arrives in the same cycle; that response is dropped and the FSM goes to REQ.
  - HOLD: ib_valid drops next cycle without a handshake, go to REQ. If ib_ready coincides, the handshake counts, since the backend flush also clears the buffer.
- Redirect target misaligned in bits [1:0]: bits are ignored (forced 0).
- PC arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
IF_PERF_CNT_EN: adds outputs perf_groups (32b, live groups delivered), perf_killed (32b, stale responses dropped) and perf_ib_stall (32b, HOLD cycles with !ib_ready). All reset to 0 and wrap. Without the macro these ports and registers are absent.

Decomposition:
- riscv_define.v gains: IF_FETCH_BYTES (16), IF_GROUP_OFF_BITS (4), IF_STATE_* encodings (BOOT/REQ/WAIT/HOLD, 2 bits).
- Sub-module if_redir_arb: combinational priority select of exc/br/pred producing next_pc and redirect_hit. It is kept separate for reuse by the future BTB update path.

Test Plan:
- Reset release, I$ always ready, 1-cycle response, ib_ready=1 -> first request 2 cycles after rst_n rises at RESET_PC; addresses RESET_PC, +16, +32; ib_mask=4'b1111.
- exc_redir_pc=0x104 in REQ unaccepted -> ic_req_addr=0x100 next cycle; delivered ib_mask=4'b1110, ib_pc=0x104.
- br_redir during WAIT, response 3 cycles later -> response dropped (no ib_valid), next request at the branch target; perf_killed=1 when IF_PERF_CNT_EN.
- pred_taken, pred_lane=1, pred_target=0x2008, fetch_pc=0x1000 -> ib_mask=4'b0011, next request 0x2000, next mask 4'b1100.
- ib_ready=0 for 5 cycles in HOLD -> ib_valid held with data stable, no new request issued; perf_ib_stall=5.
- exc and br redirect in the same cycle (0x300 vs 0x400) -> next request at 0x300.
